prim_edge_assembler: RTL

- Parametrised successor to the fixed three-vertex triangle edge sequencer.
- Accepts one primitive per handshake: point, line, triangle or quad, with up to 4 vertices. Emits that primitive's edges one at a time over a valid/ready stream to the line rasteriser.
- Adds per-primitive mode, back-pressure, optional degenerate-edge culling, last-edge flag, done pulse and a primitive counter.

---
 rtl/prim_edge_assembler.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/prim_edge_assembler.sv
// Primitive edge assembler: latches one point/line/triangle/quad and streams its
// edges to the line rasteriser, optionally skipping degenerate (zero-length) edges.
module prim_edge_assembler #(
   parameter int WIDTH      = 10,
   parameter bit CULL_DEGEN = 1'b1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           in_mode,
   input  logic [4*WIDTH-1:0]   in_x,
   input  logic [4*WIDTH-1:0]   in_y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_x0,
   output logic [WIDTH-1:0]     out_y0,
   output logic [WIDTH-1:0]     out_x1,
   output logic [WIDTH-1:0]     out_y1,
   output logic [1:0]           out_idx,
   output logic                 out_last,
   output logic                 done,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] prim_count
);

   localparam logic [1:0] MODE_POINT = 2'b00;
   localparam logic [1:0] MODE_LINE  = 2'b01;
   localparam logic [1:0] MODE_TRI   = 2'b10;

   typedef logic [WIDTH-1:0] coord_t;

   typedef struct packed {
      logic [1:0]              mode;
      logic [3:0][WIDTH-1:0]   x;
      logic [3:0][WIDTH-1:0]   y;
   } prim_t;

   typedef struct packed {
      logic   valid;
      logic   last;
      coord_t x0;
      coord_t y0;
      coord_t x1;
      coord_t y1;
   } edge_t;

   typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

   // Triangle order (v0v1, v0v2, v1v2) is fixed by the downstream rasteriser.
   function automatic logic [1:0] slot_a(input logic [1:0] mode, input logic [1:0] s);
      if (mode == MODE_TRI) return (s == 2'd2) ? 2'd1 : 2'd0;
      if (mode == MODE_POINT || mode == MODE_LINE) return 2'd0;
      return s;
   endfunction

   function automatic logic [1:0] slot_b(input logic [1:0] mode, input logic [1:0] s);
      if (mode == MODE_POINT) return 2'd0;
      if (mode == MODE_LINE) return 2'd1;
      if (mode == MODE_TRI) return (s == 2'd0) ? 2'd1 : 2'd2;
      return s + 2'd1;
   endfunction

   function automatic logic [1:0] last_slot(input logic [1:0] mode);
      case (mode)
         MODE_POINT, MODE_LINE: return 2'd0;
         MODE_TRI:              return 2'd2;
         default:               return 2'd3;
      endcase
   endfunction

   function automatic logic is_culled(input prim_t p, input logic [1:0] s);
      logic [1:0] a;
      logic [1:0] b;
      a = slot_a(p.mode, s);
      b = slot_b(p.mode, s);
      if (!CULL_DEGEN || p.mode == MODE_POINT) return 1'b0;
      return (p.x[a] == p.x[b]) && (p.y[a] == p.y[b]);
   endfunction

   // last is known up front by checking that every later slot will be culled.
   function automatic edge_t eval_slot(input prim_t p, input logic [1:0] s);
      edge_t e;
      logic [1:0] a;
      logic [1:0] b;
      a       = slot_a(p.mode, s);
      b       = slot_b(p.mode, s);
      e.x0    = p.x[a];
      e.y0    = p.y[a];
      e.x1    = p.x[b];
      e.y1    = p.y[b];
      e.valid = !is_culled(p, s);
      e.last  = e.valid;
      for (int t = 1; t < 4; t++) begin
         if (t > int'(s) && t <= int'(last_slot(p.mode)) && !is_culled(p, 2'(t)))
            e.last = 1'b0;
      end
      return e;
   endfunction

   // Asynchronous assert, release synchronised to clk.
   logic [1:0] rst_sync;
   logic       rst_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n = rst_sync[1];

   state_t     state;
   prim_t      prim_q;
   prim_t      in_prim;
   logic [1:0] slot_q;
   edge_t      first_e;
   edge_t      next_e;

   assign in_prim = {in_mode, in_x, in_y};
   assign first_e = eval_slot(in_prim, 2'd0);
   assign next_e  = eval_slot(prim_q, slot_q + 2'd1);

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         prim_q     <= '0;
         slot_q     <= 2'd0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_x0     <= '0;
         out_y0     <= '0;
         out_x1     <= '0;
         out_y1     <= '0;
         out_idx    <= 2'd0;
         done       <= 1'b0;
         prim_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  prim_q    <= in_prim;
                  slot_q    <= 2'd0;
                  state     <= EMIT;
                  out_valid <= first_e.valid;
                  out_last  <= first_e.last;
                  out_x0    <= first_e.x0;
                  out_y0    <= first_e.y0;
                  out_x1    <= first_e.x1;
                  out_y1    <= first_e.y1;
                  out_idx   <= 2'd0;
               end
            end
            EMIT: begin
               // A culled slot shows out_valid=0 and advances without a handshake.
               if (!out_valid || out_ready) begin
                  if (slot_q == last_slot(prim_q.mode)) begin
                     state      <= DONE;
                     out_valid  <= 1'b0;
                     out_last   <= 1'b0;
                     out_x0     <= '0;
                     out_y0     <= '0;
                     out_x1     <= '0;
                     out_y1     <= '0;
                     out_idx    <= 2'd0;
                     done       <= 1'b1;
                     prim_count <= prim_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                  end else begin
                     slot_q    <= slot_q + 2'd1;
                     out_valid <= next_e.valid;
                     out_last  <= next_e.last;
                     out_x0    <= next_e.x0;
                     out_y0    <= next_e.y0;
                     out_x1    <= next_e.x1;
                     out_y1    <= next_e.y1;
                     out_idx   <= slot_q + 2'd1;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
